// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM controller arbiter: FSM state encoding and port identifiers.
// Used by sram_mem_arbiter and arb_pick2.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DONE  = 2'd2
    } arb_state_t;

    localparam logic PORT_DATA = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way winner select for the SRAM arbiter.
// ARB_ROUND_ROBIN_EN: contention resolved by ptr; otherwise port 0 always wins contention.
module arb_pick2
    import sram_arb_pkg::*;
(
    input  logic [1:0] pending,
    input  logic       ptr,
    output logic       winner,
    output logic       valid
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        valid  = |pending;
        winner = PORT_DATA;
        if (pending == 2'b11) begin
            winner = ptr;
        end else if (pending[1]) begin
            winner = PORT_AUX;
        end
    end
`else
    logic ptr_unused;
    assign ptr_unused = ptr;

    always_comb begin
        valid  = |pending;
        winner = (pending[0] || !pending[1]) ? PORT_DATA : PORT_AUX;
    end
`endif

endmodule

// File: rtl/sram_mem_arbiter.sv
// Two-port arbiter in front of the single SRAM controller (port 0 = MEM stage, port 1 = aux master).
// Build option ARB_ROUND_ROBIN_EN selects round-robin contention handling instead of fixed priority.
module sram_mem_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WAIT_LIMIT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_rd,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ready,
    input  logic              p1_rd,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ready,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    input  logic [DATA_W-1:0] mem_readData,
    input  logic              mem_ready,
    output logic              grant_id,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              cmd_rd;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [CNT_W-1:0]  wait_cnt;
    logic [1:0]        pending;
    logic              pick_winner;
    logic              pick_valid;
    logic              ptr;

    assign pending = {p1_rd | p1_wr, p0_rd | p0_wr};

    arb_pick2 u_pick (
        .pending (pending),
        .ptr     (ptr),
        .winner  (pick_winner),
        .valid   (pick_valid)
    );

`ifdef ARB_ROUND_ROBIN_EN
    // The port just served loses the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= PORT_DATA;
        end else if (state == ARB_DONE) begin
            ptr <= ~grant_id;
        end
    end
`else
    assign ptr = PORT_DATA;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:  if (pick_valid) state_next = ARB_GRANT;
            ARB_GRANT: if (mem_ready)  state_next = ARB_DONE;
            ARB_DONE:  state_next = ARB_IDLE;
            default:   state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        p0_ready     = 1'b0;
        p1_ready     = 1'b0;
        case (state)
            ARB_GRANT: begin
                busy         = 1'b1;
                mem_read_en  = cmd_rd;
                mem_write_en = cmd_wr;
            end
            ARB_DONE: begin
                busy     = 1'b1;
                p0_ready = (grant_id == PORT_DATA);
                p1_ready = (grant_id == PORT_AUX);
            end
            default: ;
        endcase
    end

    assign mem_address   = cmd_addr;
    assign mem_writeData = cmd_wdata;

    // Command capture; a simultaneous rd+wr is issued as a plain write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id  <= PORT_DATA;
            cmd_rd    <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (state == ARB_IDLE && pick_valid) begin
            grant_id <= pick_winner;
            if (pick_winner == PORT_AUX) begin
                cmd_rd    <= p1_rd & ~p1_wr;
                cmd_wr    <= p1_wr;
                cmd_addr  <= p1_addr;
                cmd_wdata <= p1_wdata;
            end else begin
                cmd_rd    <= p0_rd & ~p0_wr;
                cmd_wr    <= p0_wr;
                cmd_addr  <= p0_addr;
                cmd_wdata <= p0_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ARB_GRANT) begin
                if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CNT_W'(1);
                if (wait_cnt == CNT_LIMIT) timeout_err <= 1'b1;
            end else if (state == ARB_DONE) begin
                wait_cnt <= '0;
            end
        end
    end

    // Read data stays put until the same port completes another read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else if (state == ARB_GRANT && mem_ready && cmd_rd) begin
            if (grant_id == PORT_AUX) begin
                p1_rdata <= mem_readData;
            end else begin
                p0_rdata <= mem_readData;
            end
        end
    end

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Self-checking bench for sram_mem_arbiter: the bench plays both requesters and the SRAM controller.
// Build with or without ARB_ROUND_ROBIN_EN; the reference model follows the same define.
module tb_sram_mem_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TB_WAIT = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_rd, p0_wr, p1_rd, p1_wr;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          p0_ready, p1_ready;
    logic          mem_read_en, mem_write_en;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_writeData, mem_readData;
    logic          mem_ready;
    logic          grant_id, busy, timeout_err;

    sram_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_LIMIT(TB_WAIT)) dut (
        .clk(clk), .rst(rst),
        .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ready(p0_ready),
        .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ready(p1_ready),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_readData(mem_readData), .mem_ready(mem_ready),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic          model_ptr = 1'b0;
    logic [DW-1:0] exp_rdata [2];
    logic [0:0]    exp_q [$];

    // Observations gathered while acting as the controller
    logic          s_ok, s_gid, s_rd, s_wr, s_stable;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    int            s_en_cyc, s_to_first, s_wait;

    function automatic logic model_pick(input logic pend0, input logic pend1);
        if (pend0 && pend1) begin
`ifdef ARB_ROUND_ROBIN_EN
            return model_ptr;
`else
            return 1'b0;
`endif
        end
        return pend1 && !pend0;
    endfunction

    task automatic drive_idle();
        p0_rd = 0; p0_wr = 0; p1_rd = 0; p1_wr = 0;
        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
        mem_ready = 0; mem_readData = '0;
    endtask

    // Controller model: waits for an enable, answers on the lat-th grant cycle, returns at DONE.
    task automatic serve(input int lat, input logic [DW-1:0] rdv);
        int guard;
        guard = 0;
        s_ok = 0; s_en_cyc = 0; s_stable = 1; s_to_first = 0;
        while (!(mem_read_en || mem_write_en) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        s_wait = guard;
        if (!(mem_read_en || mem_write_en)) return;
        s_ok = 1; s_gid = grant_id; s_rd = mem_read_en; s_wr = mem_write_en;
        s_addr = mem_address; s_wdata = mem_writeData;
        for (int i = 1; i <= lat; i++) begin
            if (mem_read_en || mem_write_en) s_en_cyc++;
            if (mem_read_en !== s_rd || mem_write_en !== s_wr || mem_address !== s_addr ||
                mem_writeData !== s_wdata || grant_id !== s_gid || busy !== 1'b1 ||
                p0_ready !== 1'b0 || p1_ready !== 1'b0) s_stable = 0;
            if (timeout_err && s_to_first == 0) s_to_first = i;
            if (i == lat) begin
                mem_ready = 1; mem_readData = rdv;
            end
            @(negedge clk);
        end
        mem_ready = 0; mem_readData = $urandom;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_in_rst actual=%b required=0", busy); end
        rst = 0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b required=0", busy); end
        n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant_id actual=%b required=0", grant_id); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout actual=%b required=0", timeout_err); end
        n_checks++; if (p0_rdata !== '0 || p1_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata actual=%h/%h required=0/0", p0_rdata, p1_rdata); end
        n_checks++; if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready actual=%b%b required=00", p1_ready, p0_ready); end
        n_checks++; if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en actual=%b%b required=00", mem_write_en, mem_read_en); end
        n_checks++; if (mem_address !== '0 || mem_writeData !== '0) begin n_fail++; $display("FAIL reset_mem_bus actual=%h/%h required=0/0", mem_address, mem_writeData); end
        model_ptr = 0; exp_rdata[0] = '0; exp_rdata[1] = '0;
    endtask

    task automatic test_read_latency();
        int req_cyc;
        p0_rd = 1; p0_addr = 32'h100;
        req_cyc = cyc;
        serve(3, 32'hDEADBEEF);
        n_checks++; if (!s_ok) begin n_fail++; $display("FAIL rdlat_grant actual=none required=grant"); end
        n_checks++; if (s_gid !== 1'b0 || s_rd !== 1'b1 || s_wr !== 1'b0) begin n_fail++; $display("FAIL rdlat_cmd actual=gid%b rd%b wr%b required=gid0 rd1 wr0", s_gid, s_rd, s_wr); end
        n_checks++; if (s_addr !== 32'h100) begin n_fail++; $display("FAIL rdlat_addr actual=%h required=100", s_addr); end
        n_checks++; if (s_en_cyc != 3 || !s_stable || mem_read_en !== 1'b0) begin n_fail++; $display("FAIL rdlat_en_cycles actual=%0d stable=%b en_at_done=%b required=3 1 0", s_en_cyc, s_stable, mem_read_en); end
        n_checks++; if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin n_fail++; $display("FAIL rdlat_ready actual=%b%b required=01", p1_ready, p0_ready); end
        n_checks++; if (cyc - req_cyc + 1 != 5) begin n_fail++; $display("FAIL rdlat_latency actual=%0d required=5", cyc - req_cyc + 1); end
        n_checks++; if (p0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rdlat_rdata actual=%h required=deadbeef", p0_rdata); end
        exp_rdata[0] = 32'hDEADBEEF; model_ptr = 1;
        p0_rd = 0;
        @(negedge clk);
        n_checks++; if (p0_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rdlat_one_pulse actual=rdy%b busy%b required=rdy0 busy0", p0_ready, busy); end
    endtask

    task automatic test_write();
        p1_wr = 1; p1_addr = 32'h204; p1_wdata = 32'h12345678;
        serve(2, 32'hCAFEF00D);
        n_checks++; if (!s_ok || s_gid !== 1'b1 || s_wr !== 1'b1 || s_rd !== 1'b0) begin n_fail++; $display("FAIL wr_cmd actual=ok%b gid%b rd%b wr%b required=ok1 gid1 rd0 wr1", s_ok, s_gid, s_rd, s_wr); end
        n_checks++; if (s_addr !== 32'h204 || s_wdata !== 32'h12345678) begin n_fail++; $display("FAIL wr_bus actual=%h/%h required=204/12345678", s_addr, s_wdata); end
        n_checks++; if (s_en_cyc != 2 || !s_stable) begin n_fail++; $display("FAIL wr_en_cycles actual=%0d stable=%b required=2 1", s_en_cyc, s_stable); end
        n_checks++; if (p1_ready !== 1'b1 || p0_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready actual=%b%b required=10", p1_ready, p0_ready); end
        n_checks++; if (p1_rdata !== exp_rdata[1] || p0_rdata !== exp_rdata[0]) begin n_fail++; $display("FAIL wr_rdata_kept actual=%h/%h required=%h/%h", p0_rdata, p1_rdata, exp_rdata[0], exp_rdata[1]); end
        model_ptr = 0;
        p1_wr = 0;
        @(negedge clk);
        n_checks++; if (p1_ready !== 1'b0) begin n_fail++; $display("FAIL wr_one_pulse actual=%b required=0", p1_ready); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] rdv;
        logic          exp_g;
        for (int r = 0; r < 4; r++) begin
            exp_q.push_back(model_pick(1'b1, 1'b1));
            model_ptr = ~model_pick(1'b1, 1'b1);
        end
        p0_rd = 1; p0_addr = 32'h10; p1_rd = 1; p1_addr = 32'h20;
        for (int r = 0; r < 4; r++) begin
            rdv = $urandom;
            serve(1, rdv);
            exp_g = exp_q.pop_front();
            n_checks++; if (!s_ok || s_gid !== exp_g) begin n_fail++; $display("FAIL b2b_grant round=%0d actual=%b required=%b", r, s_gid, exp_g); end
            n_checks++; if (s_addr !== (exp_g ? 32'h20 : 32'h10)) begin n_fail++; $display("FAIL b2b_addr round=%0d actual=%h required=%h", r, s_addr, exp_g ? 32'h20 : 32'h10); end
            n_checks++; if (s_wait != (r == 0 ? 1 : 2)) begin n_fail++; $display("FAIL b2b_gap round=%0d actual=%0d required=%0d", r, s_wait, r == 0 ? 1 : 2); end
            n_checks++; if (p0_ready !== !exp_g || p1_ready !== exp_g) begin n_fail++; $display("FAIL b2b_ready round=%0d actual=%b%b required=%b%b", r, p1_ready, p0_ready, exp_g, !exp_g); end
            exp_rdata[exp_g] = rdv;
            n_checks++; if (p0_rdata !== exp_rdata[0] || p1_rdata !== exp_rdata[1]) begin n_fail++; $display("FAIL b2b_rdata round=%0d actual=%h/%h required=%h/%h", r, p0_rdata, p1_rdata, exp_rdata[0], exp_rdata[1]); end
        end
        p0_rd = 0; p1_rd = 0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        p0_wr = 1; p0_addr = 32'h40; p0_wdata = 32'h55AA55AA;
        serve(TB_WAIT + 3, 32'h0BADF00D);
        n_checks++; if (!s_ok || s_to_first != TB_WAIT + 2) begin n_fail++; $display("FAIL timeout_onset actual=%0d required=%0d", s_to_first, TB_WAIT + 2); end
        n_checks++; if (p0_ready !== 1'b1 || timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_complete actual=rdy%b err%b required=rdy1 err1", p0_ready, timeout_err); end
        n_checks++; if (p0_rdata !== exp_rdata[0]) begin n_fail++; $display("FAIL timeout_rdata_kept actual=%h required=%h", p0_rdata, exp_rdata[0]); end
        model_ptr = 1;
        p0_wr = 0;
        repeat (3) @(negedge clk);
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky actual=%b required=1", timeout_err); end
    endtask

    task automatic test_rst_mid_grant();
        logic [DW-1:0] rdv;
        p1_rd = 1; p1_addr = 32'h300;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || mem_read_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_granted actual=busy%b en%b required=busy1 en1", busy, mem_read_en); end
        #2 rst = 1;
        #1;
        n_checks++; if (busy !== 1'b0 || mem_read_en !== 1'b0 || mem_write_en !== 1'b0 || p1_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_abort actual=busy%b rd%b wr%b rdy%b required=0000", busy, mem_read_en, mem_write_en, p1_ready); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_timeout_clear actual=%b required=0", timeout_err); end
        @(negedge clk);
        p1_rd = 0;
        rst = 0;
        model_ptr = 0; exp_rdata[0] = '0; exp_rdata[1] = '0;
        @(negedge clk);
        n_checks++; if (p1_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_pulse actual=rdy%b busy%b required=00", p1_ready, busy); end
        rdv = $urandom;
        p1_rd = 1; p1_addr = 32'h304;
        serve(2, rdv);
        n_checks++; if (!s_ok || s_gid !== 1'b1 || s_addr !== 32'h304 || p1_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_after actual=ok%b gid%b addr%h rdy%b required=ok1 gid1 addr304 rdy1", s_ok, s_gid, s_addr, p1_ready); end
        n_checks++; if (p1_rdata !== rdv || p0_rdata !== '0) begin n_fail++; $display("FAIL rstmid_rdata actual=%h/%h required=0/%h", p0_rdata, p1_rdata, rdv); end
        exp_rdata[1] = rdv; model_ptr = 0;
        p1_rd = 0;
        @(negedge clk);
    endtask

    task automatic test_rd_wr_both();
        p0_rd = 1; p0_wr = 1; p0_addr = 32'h80; p0_wdata = 32'hA5A5_0001;
        serve(2, 32'hFFFF0000);
        n_checks++; if (!s_ok || s_wr !== 1'b1 || s_rd !== 1'b0) begin n_fail++; $display("FAIL rdwr_as_write actual=rd%b wr%b required=rd0 wr1", s_rd, s_wr); end
        n_checks++; if (p0_ready !== 1'b1 || p0_rdata !== exp_rdata[0]) begin n_fail++; $display("FAIL rdwr_rdata_kept actual=rdy%b %h required=rdy1 %h", p0_ready, p0_rdata, exp_rdata[0]); end
        model_ptr = 1;
        p0_rd = 0; p0_wr = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [1:0]    rdq, wrq;
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        logic [DW-1:0] rdv;
        logic          w, exp_wr, exp_rd;
        int            pat, lat, kind;
        for (int it = 0; it < 40; it++) begin
            pat = $urandom_range(1, 3);
            rdq = 2'b00; wrq = 2'b00;
            for (int p = 0; p < 2; p++) begin
                a[p] = $urandom; d[p] = $urandom;
                if (pat[p]) begin
                    kind = $urandom_range(0, 2);
                    rdq[p] = (kind != 1);
                    wrq[p] = (kind != 0);
                end
            end
            w = model_pick(pat[0], pat[1]);
            exp_wr = wrq[w];
            exp_rd = rdq[w] && !wrq[w];
            p0_rd = rdq[0]; p0_wr = wrq[0]; p0_addr = a[0]; p0_wdata = d[0];
            p1_rd = rdq[1]; p1_wr = wrq[1]; p1_addr = a[1]; p1_wdata = d[1];
            lat = $urandom_range(1, 5);
            rdv = $urandom;
            serve(lat, rdv);
            n_checks++; if (!s_ok || s_gid !== w) begin n_fail++; $display("FAIL rand_grant it=%0d actual=%b required=%b", it, s_gid, w); end
            n_checks++; if (s_rd !== exp_rd || s_wr !== exp_wr) begin n_fail++; $display("FAIL rand_kind it=%0d actual=rd%b wr%b required=rd%b wr%b", it, s_rd, s_wr, exp_rd, exp_wr); end
            n_checks++; if (s_addr !== a[w] || (exp_wr && s_wdata !== d[w])) begin n_fail++; $display("FAIL rand_bus it=%0d actual=%h/%h required=%h/%h", it, s_addr, s_wdata, a[w], d[w]); end
            n_checks++; if (s_en_cyc != lat || !s_stable) begin n_fail++; $display("FAIL rand_hold it=%0d actual=%0d stable=%b required=%0d 1", it, s_en_cyc, s_stable, lat); end
            n_checks++; if (p0_ready !== !w || p1_ready !== w) begin n_fail++; $display("FAIL rand_ready it=%0d actual=%b%b required=%b%b", it, p1_ready, p0_ready, w, !w); end
            if (exp_rd) exp_rdata[w] = rdv;
            model_ptr = ~w;
            n_checks++; if (p0_rdata !== exp_rdata[0] || p1_rdata !== exp_rdata[1]) begin n_fail++; $display("FAIL rand_rdata it=%0d actual=%h/%h required=%h/%h", it, p0_rdata, p1_rdata, exp_rdata[0], exp_rdata[1]); end
            p0_rd = 0; p0_wr = 0; p1_rd = 0; p1_wr = 0;
            @(negedge clk);
            n_checks++; if (busy !== 1'b0 || p0_ready !== 1'b0 || p1_ready !== 1'b0) begin n_fail++; $display("FAIL rand_idle it=%0d actual=busy%b rdy%b%b required=busy0 rdy00", it, busy, p1_ready, p0_ready); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        rst = 1;
        drive_idle();
        test_reset();
        test_read_latency();
        test_write();
        test_back_to_back();
        test_timeout();
        test_rst_mid_grant();
        test_rd_wr_both();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
